// File: rtl/inst_sram_axi_rd_bridge_if.sv
// Bus bundle between fetch's sram-like port, the read bridge and the AXI AR/R channels.
// With INST_BRIDGE_RRESP_ERR_EN defined the bundle also carries inst_rd_err / inst_rd_err_addr.
interface inst_sram_axi_rd_bridge_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
`ifdef INST_BRIDGE_RRESP_ERR_EN
  logic        inst_rd_err;
  logic [31:0] inst_rd_err_addr;
`endif

  // slave: the bridge itself (responder to fetch, driver of AR/R ready)
  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    input  inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
`ifdef INST_BRIDGE_RRESP_ERR_EN
    , output inst_rd_err, inst_rd_err_addr
`endif
  );

  // master: the surrounding fetch stage and AXI slave
  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    output inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
`ifdef INST_BRIDGE_RRESP_ERR_EN
    , input inst_rd_err, inst_rd_err_addr
`endif
  );
endinterface

// File: rtl/inst_sram_axi_rd_bridge.sv
// Fetch sram-like read port -> single-beat AXI3 reads, returned in order with 1-cycle R latency.
// Optional INST_BRIDGE_RRESP_ERR_EN: flags non-OKAY rresp and reports the failing address.
module inst_sram_axi_rd_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AR_ID           = 4'd0
) (
  input logic clk,
  input logic reset,
  inst_sram_axi_rd_bridge_if.slave bus
);
  typedef enum logic {IDLE, AR_WAIT} state_t;

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  state_t      state;
  logic [1:0]  cnt;
  logic        addr_ok;
  logic        arvalid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        data_ok;
  logic [31:0] rdata_q;

  // Accept only from IDLE: the AR handshake cannot complete in the accept cycle.
  assign addr_ok = !reset && (state == IDLE) && bus.inst_sram_req && (cnt < MAX_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      arvalid <= 1'b0;
      araddr  <= '0;
      arsize  <= '0;
    end else begin
      case (state)
        IDLE: if (addr_ok) begin
          state   <= AR_WAIT;
          arvalid <= 1'b1;
          araddr  <= bus.inst_sram_addr;
          arsize  <= {1'b0, bus.inst_sram_size};
        end
        AR_WAIT: if (bus.arready) begin
          state   <= IDLE;
          arvalid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A stray beat with cnt==0 is still returned; the count just stays at zero.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (addr_ok && !data_ok) cnt <= cnt + 2'd1;
    else if (!addr_ok && data_ok && cnt != 2'd0) cnt <= cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok <= 1'b0;
      rdata_q <= '0;
    end else begin
      data_ok <= bus.rvalid;
      if (bus.rvalid) rdata_q <= bus.rdata;
    end
  end

  assign bus.inst_sram_addr_ok = addr_ok;
  assign bus.inst_sram_data_ok = data_ok;
  assign bus.inst_sram_rdata   = rdata_q;
  assign bus.arid    = AR_ID;
  assign bus.araddr  = araddr;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = arsize;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = arvalid;
  assign bus.rready  = 1'b1;

`ifdef INST_BRIDGE_RRESP_ERR_EN
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]   afifo [MAX_OUTSTANDING];
  logic [PW-1:0] wptr, rptr, rptr_nx;
  logic          rd_err;
  logic [31:0]   rd_err_addr;
  logic          beat_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // The beat arriving now belongs to the entry after any pop happening this cycle.
  assign rptr_nx  = data_ok ? ptr_inc(rptr) : rptr;
  assign beat_err = bus.rvalid && (bus.rresp != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      rd_err      <= 1'b0;
      rd_err_addr <= '0;
    end else begin
      if (arvalid && bus.arready) begin
        afifo[wptr] <= araddr;
        wptr        <= ptr_inc(wptr);
      end
      rptr   <= rptr_nx;
      rd_err <= beat_err;
      if (beat_err) rd_err_addr <= afifo[rptr_nx];
    end
  end

  assign bus.inst_rd_err      = rd_err;
  assign bus.inst_rd_err_addr = rd_err_addr;

  logic unused_in;
  assign unused_in = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                       bus.rid, bus.rlast};
`else
  logic unused_in;
  assign unused_in = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                       bus.rid, bus.rlast, bus.rresp};
`endif
endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Random + directed bench for inst_sram_axi_rd_bridge against a queue-based transaction model.
// Define INST_BRIDGE_RRESP_ERR_EN to also exercise the rresp error reporting.
module tb_inst_sram_axi_rd_bridge;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  inst_sram_axi_rd_bridge_if bus ();

  inst_sram_axi_rd_bridge #(.MAX_OUTSTANDING(MAXO), .AR_ID(4'd0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: accepted = accepted by fetch awaiting data_ok; issued = AR done awaiting R beat.
  logic [31:0] accepted[$];
  logic [31:0] issued[$];
  bit          ar_pend;
  logic [31:0] ar_addr_m;
  logic [2:0]  ar_size_m;
  int          cnt_m;
  bit          dok_m;
  logic [31:0] rdata_m;
  bit          err_m;
  logic [31:0] err_addr_m;
  int          force_rresp = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h1c000000: return 32'h02800c0c;
      32'h1c000100: return 32'h11111111;
      32'h1c000104: return 32'h22222222;
      default:      return {a[15:0], ~a[31:16]} ^ 32'h9e3779b9;
    endcase
  endfunction

  task automatic model_clear();
    accepted.delete();
    issued.delete();
    ar_pend = 0; ar_addr_m = '0; ar_size_m = '0; cnt_m = 0;
    dok_m = 0; rdata_m = '0; err_m = 0; err_addr_m = '0;
  endtask

  task automatic idle_inputs();
    bus.inst_sram_req = 0; bus.inst_sram_wr = 0; bus.inst_sram_size = 2'b10;
    bus.inst_sram_wstrb = '0; bus.inst_sram_addr = '0; bus.inst_sram_wdata = '0;
    bus.arready = 0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0;
    bus.rlast = 0; bus.rvalid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    @(negedge clk);
    #1;
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_addr_ok", bus.inst_sram_addr_ok, 0);
    chk("rst_data_ok", bus.inst_sram_data_ok, 0);
    chk("rst_rdata", bus.inst_sram_rdata, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_rready", bus.rready, 1);
`ifdef INST_BRIDGE_RRESP_ERR_EN
    chk("rst_err", bus.inst_rd_err, 0);
    chk("rst_err_addr", bus.inst_rd_err_addr, 0);
`endif
    reset = 0;
    model_clear();
  endtask

  // One clock: drive inputs at negedge, check outputs, then advance the model across the posedge.
  task automatic cyc(input bit rq, input logic [31:0] ad, input bit ardy, input bit rv_want);
    bit          rv, exp_aok;
    logic [1:0]  sz, rr;
    logic [31:0] exp_rd, beat_addr;
    @(negedge clk);
    sz = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b10;
    rv = rv_want && (issued.size() > 0);
    rr = (force_rresp >= 0) ? 2'(force_rresp) : (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
    bus.inst_sram_req = rq; bus.inst_sram_addr = ad; bus.inst_sram_size = sz;
    bus.inst_sram_wr = 1'($urandom); bus.inst_sram_wstrb = 4'($urandom);
    bus.inst_sram_wdata = $urandom;
    bus.arready = ardy;
    bus.rvalid = rv; bus.rdata = rv ? mem(issued[0]) : $urandom;
    bus.rresp = rr; bus.rid = 4'($urandom); bus.rlast = 1'($urandom);
    #1;
    exp_aok = rq && !ar_pend && (cnt_m < MAXO);
    exp_rd  = (dok_m && accepted.size() > 0) ? mem(accepted[0]) : rdata_m;
    chk("addr_ok", bus.inst_sram_addr_ok, exp_aok);
    chk("arvalid", bus.arvalid, ar_pend);
    if (ar_pend) begin
      chk("araddr", bus.araddr, ar_addr_m);
      chk("arsize", bus.arsize, ar_size_m);
    end
    chk("ar_const", {bus.arid, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
        {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    chk("data_ok", bus.inst_sram_data_ok, dok_m);
    chk("rdata", bus.inst_sram_rdata, exp_rd);
    chk("rready", bus.rready, 1);
`ifdef INST_BRIDGE_RRESP_ERR_EN
    chk("rd_err", bus.inst_rd_err, err_m);
    chk("rd_err_addr", bus.inst_rd_err_addr, err_addr_m);
`endif
    if (dok_m) begin
      if (accepted.size() > 0) void'(accepted.pop_front());
      rdata_m = exp_rd;
      if (cnt_m > 0 && !exp_aok) cnt_m--;
    end
    beat_addr = '0;
    if (rv) beat_addr = issued.pop_front();
    if (ar_pend && ardy) begin
      issued.push_back(ar_addr_m);
      ar_pend = 0;
    end
    if (exp_aok) begin
      ar_pend = 1; ar_addr_m = ad; ar_size_m = {1'b0, sz};
      accepted.push_back(ad);
      if (!dok_m) cnt_m++;
    end
    dok_m = rv;
    err_m = rv && (rr != 2'b00);
    if (err_m) err_addr_m = beat_addr;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    do_reset();

    // single read
    cyc(1, 32'h1c000000, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // AR back-pressure for 5 cycles
    cyc(1, 32'h1c000010, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'h1c000020, 0, 0);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    // outstanding limit: req held, R withheld, then released
    for (int i = 0; i < 8; i++) cyc(1, 32'h1c000200 + 32'(i * 4), 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'h1c000300 + 32'(i * 4), 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1);

    // simultaneous accept and return with one outstanding
    cyc(1, 32'h1c000100, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 32'h1c000104, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // reset while AR_WAIT
    cyc(1, 32'h1c000400, 0, 0);
    cyc(0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0);

`ifdef INST_BRIDGE_RRESP_ERR_EN
    cyc(1, 32'h1c000040, 0, 0);
    cyc(0, 0, 1, 0);
    force_rresp = 2;
    cyc(0, 0, 0, 1);
    force_rresp = 0;
    cyc(1, 32'h1c000044, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    force_rresp = -1;
`endif

    // randomized traffic in phases of differing pressure, with a mid-run reset
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
        if (ph == 1 && i == 300) do_reset();
        cyc($urandom_range(0, 99) < 70,
            ($urandom_range(0, 1) ? 32'h1c000000 : 32'h00400000) | (32'($urandom_range(0, 4095)) << 2),
            $urandom_range(0, 99) < (ph == 0 ? 80 : ph == 1 ? 30 : 60),
            $urandom_range(0, 99) < (ph == 2 ? 20 : 60));
      end
    end
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1);
    chk("drained", 64'(accepted.size() + issued.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
